// File: rtl/pmem_loader_if.sv
// Byte-stream, program-memory write and core-control signals of the boot loader.
// The slave modport is the loader; the master modport is the stream source / observer.
interface pmem_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        byte_dt_i;
  logic              byte_vld_i;
  logic              byte_rdy_o;
  logic              restart_i;
  logic [ADDR_W-1:0] pmem_addr_o;
  logic [31:0]       pmem_dt_o;
  logic              pmem_wr_o;
  logic              core_rst_no;
  logic              done_o;
  logic              err_o;

  modport master (
    output byte_dt_i, byte_vld_i, restart_i,
    input  byte_rdy_o, pmem_addr_o, pmem_dt_o, pmem_wr_o, core_rst_no, done_o, err_o
  );

  modport slave (
    input  byte_dt_i, byte_vld_i, restart_i,
    output byte_rdy_o, pmem_addr_o, pmem_dt_o, pmem_wr_o, core_rst_no, done_o, err_o
  );
endinterface

// File: rtl/pmem_loader.sv
// Boot loader: length byte, LE 32-bit words written from address 0, XOR checksum, core released on success.
// Write pulse one cycle after a word's 4th byte; one byte per cycle, ready drops only outside loading or on restart.
module pmem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  pmem_loader_if.slave bus
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

  localparam logic [9:0] CAP = 10'(1) << ADDR_W;

  state_t      state;
  logic [8:0]  n_words;
  logic [8:0]  word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] wbuf;
  logic [7:0]  csum;
  logic [7:0]  din;
  logic [8:0]  len_words;
  logic        take;

  assign din       = bus.byte_dt_i;
  assign len_words = (din == 8'd0) ? 9'd256 : {1'b0, din};
  assign bus.byte_rdy_o = ((state == S_LEN) || (state == S_DATA) || (state == S_CHK))
                          && !bus.restart_i;
  assign take = bus.byte_vld_i && bus.byte_rdy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= S_LEN;
      n_words         <= '0;
      word_cnt        <= '0;
      byte_cnt        <= '0;
      wbuf            <= '0;
      csum            <= '0;
      bus.pmem_addr_o <= '0;
      bus.pmem_dt_o   <= '0;
      bus.pmem_wr_o   <= 1'b0;
      bus.core_rst_no <= 1'b0;
      bus.done_o      <= 1'b0;
      bus.err_o       <= 1'b0;
    end else begin
      bus.pmem_wr_o <= 1'b0;
      if (bus.restart_i) begin
        // A partially assembled word is simply abandoned; S_LEN reinitialises the counters.
        state           <= S_LEN;
        bus.core_rst_no <= 1'b0;
        bus.done_o      <= 1'b0;
        bus.err_o       <= 1'b0;
      end else if (take) begin
        case (state)
          S_LEN: begin
            n_words  <= len_words;
            word_cnt <= '0;
            byte_cnt <= '0;
            csum     <= '0;
            if ({1'b0, len_words} > CAP) begin
              state     <= S_ERR;
              bus.err_o <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            csum     <= csum ^ din;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: wbuf[7:0]   <= din;
              2'd1: wbuf[15:8]  <= din;
              2'd2: wbuf[23:16] <= din;
              default: begin
                // The top byte goes straight to the output register, so the buffer holds only three.
                bus.pmem_dt_o   <= {din, wbuf};
                bus.pmem_addr_o <= word_cnt[ADDR_W-1:0];
                bus.pmem_wr_o   <= 1'b1;
                word_cnt        <= word_cnt + 9'd1;
                if (word_cnt == n_words - 9'd1) begin
                  state <= S_CHK;
                end
              end
            endcase
          end
          S_CHK: begin
            if (din == csum) begin
              state           <= S_RUN;
              bus.core_rst_no <= 1'b1;
              bus.done_o      <= 1'b1;
            end else begin
              state     <= S_ERR;
              bus.err_o <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed-random bench for pmem_loader: images built from random bytes, expected words and checksum
// derived from the stream format, writes captured by a monitor and compared with the image.
module tb_pmem_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   wr4_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_loader_if #(.ADDR_W(8)) bus8 ();
  pmem_loader_if #(.ADDR_W(4)) bus4 ();

  pmem_loader #(.ADDR_W(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(bus8.slave));
  pmem_loader #(.ADDR_W(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));

  typedef struct {
    int          addr;
    logic [31:0] dat;
    int          cyc;
    logic        crst;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] stream[$];
  int         acc[$];

  always @(negedge clk) begin
    if (rst_n && bus8.pmem_wr_o) begin
      wr_t e;
      e.addr = int'(bus8.pmem_addr_o);
      e.dat  = bus8.pmem_dt_o;
      e.cyc  = cyc;
      e.crst = bus8.core_rst_no;
      wq.push_back(e);
    end
    if (rst_n && bus4.pmem_wr_o) wr4_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Image: length byte, 4n random bytes, XOR checksum (optionally corrupted).
  task automatic build(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n));
    x = 8'h00;
    for (int j = 0; j < 4 * n; j++) begin
      b = 8'($urandom);
      stream.push_back(b);
      x = x ^ b;
    end
    stream.push_back(corrupt ? (x ^ 8'h5A) : x);
  endtask

  task automatic drive(input int count, input bit gaps);
    acc.delete();
    for (int i = 0; i < count; i++) begin
      bit ok;
      int c;
      ok = 1'b0;
      c  = 0;
      for (int w = 0; w < 16 && !ok; w++) begin
        @(negedge clk);
        bus8.byte_vld_i = !(gaps && ($urandom_range(0, 2) == 0));
        bus8.byte_dt_i  = bus8.byte_vld_i ? stream[i] : 8'($urandom);
        #1;
        c  = cyc;
        ok = bus8.byte_vld_i && bus8.byte_rdy_o;
        @(posedge clk);
      end
      if (!ok) begin
        chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus8.byte_vld_i = 1'b0;
        return;
      end
      acc.push_back(c);
    end
    @(negedge clk);
    bus8.byte_vld_i = 1'b0;
    #1;
  endtask

  task automatic check_writes(input string tag, input int n, input bit spacing);
    chk({tag, "_cnt"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      logic [31:0] w;
      w = {stream[4*i+4], stream[4*i+3], stream[4*i+2], stream[4*i+1]};
      chk({tag, "_addr"}, 64'(wq[i].addr), 64'(i));
      chk({tag, "_data"}, 64'(wq[i].dat), 64'(w));
      chk({tag, "_crst_during_wr"}, 64'(wq[i].crst), 64'd0);
      if (acc.size() > 4 * i + 4)
        chk({tag, "_wr_latency"}, 64'(wq[i].cyc), 64'(acc[4*i+4] + 1));
      if (spacing && i > 0)
        chk({tag, "_spacing"}, 64'(wq[i].cyc - wq[i-1].cyc), 64'd4);
    end
    wq.delete();
  endtask

  task automatic pulse_restart(input string tag);
    @(negedge clk);
    bus8.restart_i  = 1'b1;
    bus8.byte_vld_i = 1'b1;
    bus8.byte_dt_i  = 8'h01;
    #1;
    chk({tag, "_rdy_in_restart"}, 64'(bus8.byte_rdy_o), 64'd0);
    @(negedge clk);
    bus8.restart_i  = 1'b0;
    bus8.byte_vld_i = 1'b0;
    #1;
    chk({tag, "_done_clr"}, 64'(bus8.done_o), 64'd0);
    chk({tag, "_err_clr"}, 64'(bus8.err_o), 64'd0);
    chk({tag, "_crst_low"}, 64'(bus8.core_rst_no), 64'd0);
    chk({tag, "_rdy_len"}, 64'(bus8.byte_rdy_o), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(bus8.byte_rdy_o), 64'd1);
    chk({tag, "_addr"}, 64'(bus8.pmem_addr_o), 64'd0);
    chk({tag, "_dt"}, 64'(bus8.pmem_dt_o), 64'd0);
    chk({tag, "_wr"}, 64'(bus8.pmem_wr_o), 64'd0);
    chk({tag, "_crst"}, 64'(bus8.core_rst_no), 64'd0);
    chk({tag, "_done"}, 64'(bus8.done_o), 64'd0);
    chk({tag, "_err"}, 64'(bus8.err_o), 64'd0);
  endtask

  initial begin
    bus8.byte_dt_i  = 8'h00;
    bus8.byte_vld_i = 1'b0;
    bus8.restart_i  = 1'b0;
    bus4.byte_dt_i  = 8'h00;
    bus4.byte_vld_i = 1'b0;
    bus4.restart_i  = 1'b0;
    rst_n = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset4_rdy", 64'(bus4.byte_rdy_o), 64'd1);
    chk("reset4_err", 64'(bus4.err_o), 64'd0);
    rst_n = 1'b1;

    // Fixed single-word image.
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h11);
    stream.push_back(8'h22);
    stream.push_back(8'h33);
    stream.push_back(8'h44);
    stream.push_back(8'h44);
    drive(6, 1'b0);
    chk("t1_data_fixed", 64'(wq.size() > 0 ? wq[0].dat : 32'h0), 64'h44332211);
    check_writes("t1", 1, 1'b0);
    chk("t1_done", 64'(bus8.done_o), 64'd1);
    chk("t1_crst", 64'(bus8.core_rst_no), 64'd1);
    chk("t1_err", 64'(bus8.err_o), 64'd0);
    chk("t1_rdy_run", 64'(bus8.byte_rdy_o), 64'd0);
    pulse_restart("t1r");

    // Three words with random idle gaps.
    build(3, 1'b0);
    drive(14, 1'b1);
    check_writes("t2", 3, 1'b0);
    chk("t2_done", 64'(bus8.done_o), 64'd1);
    chk("t2_crst", 64'(bus8.core_rst_no), 64'd1);
    pulse_restart("t2r");

    // Corrupted checksum.
    build(1, 1'b1);
    drive(6, 1'b0);
    check_writes("t3", 1, 1'b0);
    chk("t3_err", 64'(bus8.err_o), 64'd1);
    chk("t3_done", 64'(bus8.done_o), 64'd0);
    chk("t3_crst", 64'(bus8.core_rst_no), 64'd0);
    chk("t3_rdy_err", 64'(bus8.byte_rdy_o), 64'd0);
    pulse_restart("t3r");

    // Capacity limit on the 16-word instance: 17 is rejected, 16 is accepted.
    @(negedge clk);
    bus4.byte_dt_i  = 8'd17;
    bus4.byte_vld_i = 1'b1;
    #1;
    chk("t4_rdy_len", 64'(bus4.byte_rdy_o), 64'd1);
    @(negedge clk);
    bus4.byte_vld_i = 1'b0;
    #1;
    chk("t4_err", 64'(bus4.err_o), 64'd1);
    chk("t4_rdy_err", 64'(bus4.byte_rdy_o), 64'd0);
    chk("t4_crst", 64'(bus4.core_rst_no), 64'd0);
    repeat (6) @(negedge clk);
    chk("t4_no_writes", 64'(wr4_cnt), 64'd0);
    bus4.restart_i = 1'b1;
    @(negedge clk);
    bus4.restart_i  = 1'b0;
    bus4.byte_dt_i  = 8'd16;
    bus4.byte_vld_i = 1'b1;
    #1;
    chk("t4_err_clr", 64'(bus4.err_o), 64'd0);
    @(negedge clk);
    bus4.byte_vld_i = 1'b0;
    #1;
    chk("t4_cap_ok_err", 64'(bus4.err_o), 64'd0);
    chk("t4_cap_ok_rdy", 64'(bus4.byte_rdy_o), 64'd1);

    // Restart after six data bytes of a two-word load.
    build(2, 1'b0);
    drive(7, 1'b0);
    pulse_restart("t5r");
    repeat (6) @(negedge clk);
    check_writes("t5", 1, 1'b0);
    build(1, 1'b0);
    drive(6, 1'b0);
    check_writes("t5b", 1, 1'b0);
    chk("t5b_done", 64'(bus8.done_o), 64'd1);
    pulse_restart("t5br");

    // Reset mid-word.
    build(2, 1'b0);
    drive(6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check_writes("t6", 1, 1'b0);
    check_reset_outputs("t6_after");

    // Full-rate 256-word image.
    build(256, 1'b0);
    drive(1026, 1'b0);
    check_writes("t7", 256, 1'b1);
    chk("t7_done", 64'(bus8.done_o), 64'd1);
    chk("t7_crst", 64'(bus8.core_rst_no), 64'd1);
    chk("t7_err", 64'(bus8.err_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
